pixel_mem_arbiter: RTL

Shares the single-port new-image pixel RAM (256x256 = 65536 words x 24-bit RGB, 16-bit address) between two clients: the VGA display read path and the image-processing engine, which both writes and reads. VGA reads have absolute priority so display timing is never disturbed. Processing writes are absorbed by a small write buffer and drained in idle memory cycles. Processing reads are ordered behind buffered writes.

---
 rtl/pixel_mem_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/pixel_mem_arbiter.sv
// Single-port pixel RAM arbiter: VGA reads first, then buffered write drain, then processing reads.
// Optional ARB_STATS_EN adds stat_clr, stat_vga_block and stat_wr_full.
module pixel_mem_arbiter #(
  parameter int WBUF_DEPTH = 4,
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic [DATA_W-1:0] vga_data,
  output logic              vga_valid,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_data_valid,
  output logic              wbuf_empty,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef ARB_STATS_EN
  ,
  input  logic              stat_clr,
  output logic [31:0]       stat_vga_block,
  output logic [31:0]       stat_wr_full
`endif
);

  localparam int PTR_W = $clog2(WBUF_DEPTH);

  typedef enum logic [1:0] {TAG_NONE, TAG_VGA, TAG_PROC} tag_t;

  tag_t              tag;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    count;
  logic [ADDR_W-1:0] fifo_addr [WBUF_DEPTH];
  logic [DATA_W-1:0] fifo_data [WBUF_DEPTH];
  logic [ADDR_W-1:0] last_addr;
  logic [DATA_W-1:0] last_wdata;
  logic [DATA_W-1:0] vga_hold, rd_hold;
  logic              slot_vga, slot_wr, slot_rd;
  logic              full, push;

  assign full       = (count == (PTR_W+1)'(WBUF_DEPTH));
  assign wr_ready   = !rst && !full;
  assign push       = wr_valid && wr_ready;
  assign wbuf_empty = (count == '0);

  always_comb begin
    slot_vga = 1'b0;
    slot_wr  = 1'b0;
    slot_rd  = 1'b0;
    if (!rst) begin
      if (vga_req)             slot_vga = 1'b1;
      else if (count != '0)    slot_wr  = 1'b1;
      else if (rd_valid)       slot_rd  = 1'b1;
    end
  end

  assign rd_ready = slot_rd;
  assign mem_we   = slot_wr;

  // Idle cycles re-present the previous address/data so the RAM bus stays quiet.
  always_comb begin
    mem_addr  = last_addr;
    mem_wdata = last_wdata;
    if (slot_vga) begin
      mem_addr = vga_addr;
    end else if (slot_wr) begin
      mem_addr  = fifo_addr[rd_ptr];
      mem_wdata = fifo_data[rd_ptr];
    end else if (slot_rd) begin
      mem_addr = rd_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= wr_addr;
      fifo_data[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      tag        <= TAG_NONE;
      last_addr  <= '0;
      last_wdata <= '0;
      vga_hold   <= '0;
      rd_hold    <= '0;
    end else begin
      last_addr  <= mem_addr;
      last_wdata <= mem_wdata;
      if (push)    wr_ptr <= wr_ptr + 1'b1;
      if (slot_wr) rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, slot_wr})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (slot_vga)     tag <= TAG_VGA;
      else if (slot_rd) tag <= TAG_PROC;
      else              tag <= TAG_NONE;
      if (tag == TAG_VGA)  vga_hold <= mem_rdata;
      if (tag == TAG_PROC) rd_hold  <= mem_rdata;
    end
  end

  assign vga_valid     = (tag == TAG_VGA);
  assign rd_data_valid = (tag == TAG_PROC);
  assign vga_data      = vga_valid ? mem_rdata : vga_hold;
  assign rd_data       = rd_data_valid ? mem_rdata : rd_hold;

`ifdef ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_vga_block <= '0;
      stat_wr_full   <= '0;
    end else if (stat_clr) begin
      stat_vga_block <= '0;
      stat_wr_full   <= '0;
    end else begin
      if (vga_req && (count != '0 || rd_valid) && stat_vga_block != '1)
        stat_vga_block <= stat_vga_block + 1'b1;
      if (wr_valid && !wr_ready && stat_wr_full != '1)
        stat_wr_full <= stat_wr_full + 1'b1;
    end
  end
`endif

endmodule
